ux607_pwm_deadtime: RTL and testbench

//  Downstream stage of the 4-channel PWM core. Takes each raw PWM gpio output and drives a

---
 rtl/ux607_pwm_deadtime.sv | 143 ++++++++++++++
 tb/tb_ux607_pwm_deadtime.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ux607_pwm_deadtime.sv
// Complementary high/low-side driver with programmable dead time on both edges, one
// pair per PWM core output. Outputs decode registered state only, so the pair never overlaps.
module ux607_pwm_deadtime #(
    parameter int NCH = 4,
    parameter int DTW = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    io_pwm_in,
    input  logic              io_cfg_write_valid,
    input  logic [31:0]       io_cfg_write_bits,
    output logic [31:0]       io_cfg_read,
    output logic [2*NCH-1:0]  io_state_read,
    output logic [NCH-1:0]    io_hi,
    output logic [NCH-1:0]    io_lo,
    output logic              io_busy
);

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_LO  = 2'd1,
        ST_DT  = 2'd2,
        ST_HI  = 2'd3
    } state_t;

    logic [7:0]     dt_rise_q;
    logic [7:0]     dt_fall_q;
    logic [NCH-1:0] en_q;
    logic [NCH-1:0] inv_lo_q;

    logic [DTW-1:0] rise_ld;
    logic [DTW-1:0] fall_ld;
    logic           cfg_unused;

    state_t         state_q [NCH];
    state_t         state_d [NCH];
    logic           dir_q   [NCH];
    logic           dir_d   [NCH];
    logic [DTW-1:0] cnt_q   [NCH];
    logic [DTW-1:0] cnt_d   [NCH];

    assign rise_ld     = DTW'(dt_rise_q);
    assign fall_ld     = DTW'(dt_fall_q);
    assign cfg_unused  = ^io_cfg_write_bits[31:24];
    assign io_cfg_read = {8'h00, inv_lo_q, en_q, dt_fall_q, dt_rise_q};

    always_ff @(posedge clock) begin
        if (reset) begin
            dt_rise_q <= '0;
            dt_fall_q <= '0;
            en_q      <= '0;
            inv_lo_q  <= '0;
        end else if (io_cfg_write_valid) begin
            dt_rise_q <= io_cfg_write_bits[7:0];
            dt_fall_q <= io_cfg_write_bits[15:8];
            en_q      <= io_cfg_write_bits[16 +: NCH];
            inv_lo_q  <= io_cfg_write_bits[20 +: NCH];
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                state_q[i] <= ST_OFF;
                dir_q[i]   <= 1'b0;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                dir_q[i]   <= dir_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // dir selects DT_UP (1, heading to HI) or DT_DN (0, heading to LO); an input that
    // reverses during dead time jumps straight back to the side that was already driven.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            dir_d[i]   = dir_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!en_q[i]) begin
                state_d[i] = ST_OFF;
                dir_d[i]   = 1'b0;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    ST_OFF: begin
                        state_d[i] = ST_DT;
                        dir_d[i]   = io_pwm_in[i];
                        cnt_d[i]   = io_pwm_in[i] ? rise_ld : fall_ld;
                    end
                    ST_LO: begin
                        if (io_pwm_in[i]) begin
                            if (rise_ld == '0) begin
                                state_d[i] = ST_HI;
                            end else begin
                                state_d[i] = ST_DT;
                                dir_d[i]   = 1'b1;
                                cnt_d[i]   = rise_ld - DTW'(1);
                            end
                        end
                    end
                    ST_HI: begin
                        if (!io_pwm_in[i]) begin
                            if (fall_ld == '0) begin
                                state_d[i] = ST_LO;
                            end else begin
                                state_d[i] = ST_DT;
                                dir_d[i]   = 1'b0;
                                cnt_d[i]   = fall_ld - DTW'(1);
                            end
                        end
                    end
                    ST_DT: begin
                        if (io_pwm_in[i] != dir_q[i]) begin
                            state_d[i] = dir_q[i] ? ST_LO : ST_HI;
                        end else if (cnt_q[i] == '0) begin
                            state_d[i] = dir_q[i] ? ST_HI : ST_LO;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DTW'(1);
                        end
                    end
                    default: state_d[i] = ST_OFF;
                endcase
            end
        end
    end

    always_comb begin
        io_hi         = '0;
        io_lo         = '0;
        io_state_read = '0;
        io_busy       = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            io_hi[i]              = (state_q[i] == ST_HI);
            io_lo[i]              = (state_q[i] == ST_LO) ^ inv_lo_q[i];
            io_state_read[2*i +: 2] = state_q[i];
            io_busy               = io_busy | (state_q[i] == ST_DT);
        end
    end

endmodule

// File: tb/tb_ux607_pwm_deadtime.sv
// Bench for ux607_pwm_deadtime: hand-derived vector table, then dead-time wrap, reset
// mid-dead-time and a random soak, all checked against a behavioural scoreboard model.
module tb_ux607_pwm_deadtime;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  io_pwm_in;
    logic        io_cfg_write_valid;
    logic [31:0] io_cfg_write_bits;
    logic [31:0] io_cfg_read;
    logic [7:0]  io_state_read;
    logic [3:0]  io_hi;
    logic [3:0]  io_lo;
    logic        io_busy;

    always #5 clock = ~clock;

    ux607_pwm_deadtime #(.NCH(4), .DTW(8)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_pwm_in          (io_pwm_in),
        .io_cfg_write_valid (io_cfg_write_valid),
        .io_cfg_write_bits  (io_cfg_write_bits),
        .io_cfg_read        (io_cfg_read),
        .io_state_read      (io_state_read),
        .io_hi              (io_hi),
        .io_lo              (io_lo),
        .io_busy            (io_busy)
    );

    typedef struct {
        logic [3:0]  hi;
        logic [3:0]  lo;
        logic        busy;
        logic [7:0]  st;
        logic [31:0] cfg;
    } exp_t;

    typedef struct {
        logic        rst;
        logic [3:0]  pin;
        logic        wv;
        logic [31:0] wb;
        logic [3:0]  expHi;
        logic [3:0]  expLo;
        logic        expBusy;
    } vec_t;

    exp_t sbQueue[$];
    vec_t vecs[$];
    int   testsRun = 0;
    int   testsFailed = 0;

    logic [1:0] mSt [4];
    logic       mDir[4];
    int         mCnt[4];
    logic [7:0] mDtR, mDtF;
    logic [3:0] mEn, mInv;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one call per clock edge, using the config that was live before it.
    task automatic modelEdge(input logic rst, input logic [3:0] pin, input logic wv,
                             input logic [31:0] wb);
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                mSt[c] = 2'd0; mDir[c] = 1'b0; mCnt[c] = 0;
            end
            mDtR = 8'h0; mDtF = 8'h0; mEn = 4'h0; mInv = 4'h0;
            return;
        end
        for (int c = 0; c < 4; c++) begin
            logic inb;
            inb = pin[c];
            if (!mEn[c]) begin
                mSt[c] = 2'd0; mCnt[c] = 0;
            end else begin
                case (mSt[c])
                    2'd0: begin
                        mSt[c] = 2'd2; mDir[c] = inb;
                        mCnt[c] = inb ? int'(mDtR) : int'(mDtF);
                    end
                    2'd1: if (inb) begin
                        if (mDtR == 8'd0) mSt[c] = 2'd3;
                        else begin mSt[c] = 2'd2; mDir[c] = 1'b1; mCnt[c] = int'(mDtR) - 1; end
                    end
                    2'd3: if (!inb) begin
                        if (mDtF == 8'd0) mSt[c] = 2'd1;
                        else begin mSt[c] = 2'd2; mDir[c] = 1'b0; mCnt[c] = int'(mDtF) - 1; end
                    end
                    default: begin
                        if (inb != mDir[c] || mCnt[c] == 0) mSt[c] = inb ? 2'd3 : 2'd1;
                        else mCnt[c] = mCnt[c] - 1;
                    end
                endcase
            end
        end
        if (wv) begin
            mDtR = wb[7:0]; mDtF = wb[15:8]; mEn = wb[19:16]; mInv = wb[23:20];
        end
    endtask

    function automatic exp_t modelOut();
        exp_t e;
        e.hi = '0; e.lo = '0; e.busy = 1'b0; e.st = '0;
        for (int c = 0; c < 4; c++) begin
            e.hi[c] = (mSt[c] == 2'd3);
            e.lo[c] = (mSt[c] == 2'd1) ^ mInv[c];
            e.busy  = e.busy | (mSt[c] == 2'd2);
            e.st[2*c +: 2] = mSt[c];
        end
        e.cfg = {8'h00, mInv, mEn, mDtF, mDtR};
        return e;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [3:0] pin, input logic wv,
                                 input logic [31:0] wb);
        reset              = rst;
        io_pwm_in          = pin;
        io_cfg_write_valid = wv;
        io_cfg_write_bits  = wb;
        modelEdge(rst, pin, wv, wb);
        sbQueue.push_back(modelOut());
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQueue.size() == 0) begin
            cmp("sb_empty", 32'(sbQueue.size()), 32'd1);
            return;
        end
        e = sbQueue.pop_front();
        cmp("hi",      32'(io_hi),         32'(e.hi));
        cmp("lo",      32'(io_lo),         32'(e.lo));
        cmp("busy",    32'(io_busy),       32'(e.busy));
        cmp("state",   32'(io_state_read), 32'(e.st));
        cmp("cfg",     io_cfg_read,        e.cfg);
        cmp("overlap", 32'(io_hi & (io_lo ^ mInv)), 32'd0);
    endtask

    task automatic addVec(input logic rst, input logic [3:0] pin, input logic wv,
                          input logic [31:0] wb, input logic [3:0] h, input logic [3:0] l,
                          input logic b);
        vec_t v;
        v.rst = rst; v.pin = pin; v.wv = wv; v.wb = wb;
        v.expHi = h; v.expLo = l; v.expBusy = b;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] r;
        int         firstHi;

        // Channel 0: dt_rise=3, dt_fall=2, then dt_rise=5 pulse swallow, dt=0, inv_lo and disable.
        addVec(1, 4'h0, 0, 32'h0,        4'h0, 4'h0, 0);
        addVec(0, 4'h0, 1, 32'h00010203, 4'h0, 4'h0, 0);
        addVec(0, 4'h0, 0, 32'h0,        4'h0, 4'h0, 1);
        addVec(0, 4'h0, 0, 32'h0,        4'h0, 4'h0, 1);
        addVec(0, 4'h0, 0, 32'h0,        4'h0, 4'h0, 1);
        addVec(0, 4'h0, 0, 32'h0,        4'h0, 4'h1, 0);
        addVec(0, 4'h1, 0, 32'h0,        4'h0, 4'h0, 1);
        addVec(0, 4'h1, 0, 32'h0,        4'h0, 4'h0, 1);
        addVec(0, 4'h1, 0, 32'h0,        4'h0, 4'h0, 1);
        addVec(0, 4'h1, 0, 32'h0,        4'h1, 4'h0, 0);
        addVec(0, 4'h1, 0, 32'h0,        4'h1, 4'h0, 0);
        addVec(0, 4'h0, 0, 32'h0,        4'h0, 4'h0, 1);
        addVec(0, 4'h0, 0, 32'h0,        4'h0, 4'h0, 1);
        addVec(0, 4'h0, 0, 32'h0,        4'h0, 4'h1, 0);
        addVec(0, 4'h0, 0, 32'h0,        4'h0, 4'h1, 0);
        addVec(0, 4'h0, 1, 32'h00010205, 4'h0, 4'h1, 0);
        addVec(0, 4'h1, 0, 32'h0,        4'h0, 4'h0, 1);
        addVec(0, 4'h1, 0, 32'h0,        4'h0, 4'h0, 1);
        addVec(0, 4'h0, 0, 32'h0,        4'h0, 4'h1, 0);
        addVec(0, 4'h0, 0, 32'h0,        4'h0, 4'h1, 0);
        addVec(0, 4'h0, 1, 32'h00010000, 4'h0, 4'h1, 0);
        addVec(0, 4'h1, 0, 32'h0,        4'h1, 4'h0, 0);
        addVec(0, 4'h0, 0, 32'h0,        4'h0, 4'h1, 0);
        addVec(0, 4'h1, 0, 32'h0,        4'h1, 4'h0, 0);
        addVec(0, 4'h1, 0, 32'h0,        4'h1, 4'h0, 0);
        addVec(0, 4'h0, 0, 32'h0,        4'h0, 4'h1, 0);
        addVec(0, 4'h0, 1, 32'h00F10303, 4'h0, 4'hE, 0);
        addVec(0, 4'h1, 0, 32'h0,        4'h0, 4'hF, 1);
        addVec(0, 4'h1, 1, 32'h00F00303, 4'h0, 4'hF, 1);
        addVec(0, 4'h1, 0, 32'h0,        4'h0, 4'hF, 0);
        addVec(0, 4'h0, 1, 32'h0,        4'h0, 4'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].pin, vecs[i].wv, vecs[i].wb);
            cmp($sformatf("vec%0d_hi", i),   32'(io_hi),   32'(vecs[i].expHi));
            cmp($sformatf("vec%0d_lo", i),   32'(io_lo),   32'(vecs[i].expLo));
            cmp($sformatf("vec%0d_busy", i), 32'(io_busy), 32'(vecs[i].expBusy));
            checkOutput();
        end

        // Maximum dead time: from OFF the count loads 255 directly, so HI appears on edge 257.
        applyStimulus(0, 4'h1, 1, 32'h0001FFFF);
        checkOutput();
        firstHi = 0;
        for (int n = 1; n <= 300 && firstHi == 0; n++) begin
            applyStimulus(0, 4'h1, 0, 32'h0);
            checkOutput();
            if (io_hi[0]) firstHi = n;
        end
        cmp("wrap_first_hi_edge", 32'(firstHi), 32'd257);

        // Reset in the middle of a long dead time on all channels.
        applyStimulus(1, 4'h0, 0, 32'h0);
        checkOutput();
        r = 4'($urandom_range(15));
        applyStimulus(0, r, 1, 32'h000FFFFF);
        checkOutput();
        for (int n = 0; n < 10; n++) begin
            applyStimulus(0, r, 0, 32'h0);
            checkOutput();
        end
        cmp("busy_before_reset",  32'(io_busy),       32'd1);
        cmp("state_before_reset", 32'(io_state_read), 32'hAA);
        applyStimulus(1, 4'($urandom_range(15)), 0, 32'h0);
        checkOutput();
        cmp("reset_hi",   32'(io_hi),   32'd0);
        cmp("reset_lo",   32'(io_lo),   32'd0);
        cmp("reset_busy", 32'(io_busy), 32'd0);

        // Random soak with short dead times and occasional reconfiguration or reset.
        for (int n = 0; n < 600; n++) begin
            logic        wv;
            logic [31:0] wb;
            wv = ($urandom_range(19) == 0);
            wb = {8'h00, 4'($urandom_range(15)), 4'($urandom_range(15)),
                  8'($urandom_range(3)), 8'($urandom_range(3))};
            applyStimulus($urandom_range(149) == 0, 4'($urandom_range(15)), wv, wb);
            checkOutput();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
